// File: rtl/calc_input_pkg.sv
// Shared types and constants for the calculator keypad input path.
// Frame classification helper used by the keypad scanner.
package calc_input_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED
    } scan_state_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_class_t;

    typedef struct packed {
        frame_class_t cls;
        logic [3:0]   code;
    } frame_info_t;

    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_7     = 4'd7;
    localparam logic [3:0] KEY_8     = 4'd8;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_ADD   = 4'd10;
    localparam logic [3:0] KEY_SUB   = 4'd11;
    localparam logic [3:0] KEY_SIGN  = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;
    localparam logic [3:0] KEY_EQ    = 4'd14;
    localparam logic [3:0] KEY_SPARE = 4'd15;

    // hits[k] set means intersection k = row*4+col was seen low this frame
    function automatic frame_info_t classify(input logic [NUM_KEYS-1:0] hits);
        frame_info_t info;
        logic [1:0]  n;
        n         = 2'd0;
        info.code = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (hits[i]) begin
                info.code = 4'(i);
                if (n != 2'd2) n = n + 2'd1;
            end
        end
        unique case (n)
            2'd0:    info.cls = NONE;
            2'd1:    info.cls = SINGLE;
            default: info.cls = MULTI;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous matrix rows.
// Resets to all-ones so idle (pulled-up) rows read as released.
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobe, frame capture, frame debounce.
// Emits one key_valid pulse per accepted press; key_held tracks release.
module keypad_scanner
    import calc_input_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

    logic [3:0]          w_rows_s;
    logic [DIV_W-1:0]    r_div;
    logic [1:0]          r_col;
    logic [NUM_KEYS-1:0] r_hits;
    logic [NUM_KEYS-1:0] w_hits;
    logic                w_tick;
    logic                w_frame_done;
    frame_info_t         w_info;

    scan_state_t      r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt, w_cnt_inc;
    logic [3:0]       r_cand, w_cand;
    logic [3:0]       r_code, w_code;
    logic             r_valid, w_valid;
    logic             r_held, w_held;

    key_sync #(.WIDTH(NUM_ROWS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (row_n),
        .o_q   (w_rows_s)
    );

    assign w_tick       = (r_div == DIV_LAST);
    assign w_frame_done = w_tick && (r_col == 2'd3);
    assign col_n        = ~(4'b0001 << r_col);

    // Current column's bits are replaced by the live sample
    always_comb begin
        w_hits = r_hits;
        for (int r = 0; r < NUM_ROWS; r++) begin
            w_hits[{2'(r), r_col}] = ~w_rows_s[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_col  <= 2'd0;
            r_hits <= '0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_col  <= r_col + 2'd1;
            r_hits <= w_hits;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    assign w_info    = classify(w_hits);
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_cand  = r_cand;
        w_code  = r_code;
        w_valid = 1'b0;
        w_held  = r_held;
        if (w_frame_done) begin
            unique case (r_state)
                IDLE: begin
                    if (w_info.cls == SINGLE) begin
                        w_cand  = w_info.code;
                        w_cnt   = CNT_W'(1);
                        w_state = DEBOUNCE;
                        if (CNT_MAX == CNT_W'(1)) begin
                            w_code  = w_info.code;
                            w_valid = 1'b1;
                            w_held  = 1'b1;
                            w_cnt   = '0;
                            w_state = PRESSED;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_info.cls == SINGLE && w_info.code == r_cand) begin
                        w_cnt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_code  = r_cand;
                            w_valid = 1'b1;
                            w_held  = 1'b1;
                            w_cnt   = '0;
                            w_state = PRESSED;
                        end
                    end else if (w_info.cls == SINGLE) begin
                        w_cand = w_info.code;
                        w_cnt  = CNT_W'(1);
                    end else begin
                        w_cnt   = '0;
                        w_state = IDLE;
                    end
                end
                PRESSED: begin
                    if (w_info.cls == NONE) begin
                        w_cnt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_held  = 1'b0;
                            w_cnt   = '0;
                            w_state = IDLE;
                        end
                    end else begin
                        w_cnt = '0;
                    end
                end
                default: begin
                    w_cnt   = '0;
                    w_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
            r_code  <= 4'd0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_cand  <= w_cand;
            r_code  <= w_code;
            r_valid <= w_valid;
            r_held  <= w_held;
        end
    end

    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, 3 debounce frames).
// Key matrix model plus a queue of expected key_valid codes.
module tb_keypad_scanner;
    import calc_input_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0000;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    logic prev_valid = 1'b0;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        bit          push;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    // Pressed key k = row*4+col shorts its row to its column when driven low
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * 16) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && key_valid) begin
            if (prev_valid) begin
                total++;
                bad++;
                $display("FAIL pulse_width: key_valid high two cycles");
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: code %h, none expected",
                         key_code);
            end else begin
                check("pulse_code", 16'(key_code), 16'(exp_q.pop_front()));
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        logic [3:0] ec;
        vec_t v;

        tbl.push_back('{16'h0040, 5, 1'b1, 4'd6, 1'b1});
        tbl.push_back('{16'h0000, 3, 1'b0, 4'd6, 1'b0});
        for (int i = 0; i < 4; i++) begin
            tbl.push_back('{16'h0040, 1, 1'b0, 4'd6, 1'b0});
            tbl.push_back('{16'h0000, 1, 1'b0, 4'd6, 1'b0});
        end
        tbl.push_back('{16'h0040, 3, 1'b1, 4'd6, 1'b1});
        tbl.push_back('{16'h0000, 3, 1'b0, 4'd6, 1'b0});
        tbl.push_back('{16'h8001, 6, 1'b0, 4'd6, 1'b0});
        tbl.push_back('{16'h0000, 1, 1'b0, 4'd6, 1'b0});
        tbl.push_back('{16'h0200, 3, 1'b1, 4'd9, 1'b1});
        tbl.push_back('{16'h0000, 2, 1'b0, 4'd9, 1'b1});
        tbl.push_back('{16'h0200, 2, 1'b0, 4'd9, 1'b1});
        tbl.push_back('{16'h0000, 3, 1'b0, 4'd9, 1'b0});
        tbl.push_back('{16'h0008, 3, 1'b1, 4'd3, 1'b1});
        tbl.push_back('{16'h0000, 3, 1'b0, 4'd3, 1'b0});

        repeat (3) @(negedge clk);
        check("rst_col_n", 16'(col_n), 16'h000E);
        check("rst_valid", 16'(key_valid), 16'h0);
        check("rst_held", 16'(key_held), 16'h0);
        check("rst_code", 16'(key_code), 16'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            ec = ~(4'b0001 << (k / 4));
            check("col_seq", 16'(col_n), 16'(ec));
            @(negedge clk);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            keys = v.keys;
            if (v.push) exp_q.push_back(v.code);
            frames(v.frames);
            check($sformatf("held_%0d", i), 16'(key_held), 16'(v.held));
            check($sformatf("code_%0d", i), 16'(key_code), 16'(v.code));
            check($sformatf("drain_%0d", i), 16'(exp_q.size()), 16'h0);
        end

        keys = 16'h0020;
        frames(2);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_col_n", 16'(col_n), 16'h000E);
        check("arst_valid", 16'(key_valid), 16'h0);
        check("arst_held", 16'(key_held), 16'h0);
        check("arst_code", 16'(key_code), 16'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'd5);
        frames(2);
        check("arst_no_early", 16'(exp_q.size()), 16'h1);
        check("arst_held_early", 16'(key_held), 16'h0);
        frames(1);
        check("arst_pulse", 16'(exp_q.size()), 16'h0);
        check("arst_held", 16'(key_held), 16'h1);
        check("arst_code5", 16'(key_code), 16'h5);
        keys = 16'h0000;
        frames(3);
        check("final_release", 16'(key_held), 16'h0);
        check("final_drain", 16'(exp_q.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
